serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Bit-serial adder-subtracter for the SAP datapath: computes A+B or A−B one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Sequential counterpart to the parallel four-bit adder. Trades latency for one adder cell.
- Driven by the controller with a START/DONE handshake. Result and flags are held until the next operation.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).
- CW, $clog2(WIDTH+1), bit counter width (derived, localparam).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- START  in  1  begin operation; sampled only in IDLE.
- SU  in  1  0 = add, 1 = subtract (A−B); latched with START.
- A  in  WIDTH  operand A; latched with START.
- B  in  WIDTH  operand B; latched with START.
- BUSY  out  1  high while bits are being processed.
- DONE  out  1  one-cycle pulse when RESULT/flags are valid.
- RESULT  out  WIDTH  sum/difference, held until next DONE.
- CARRY  out  1  final carry out; on subtract, 1 = no borrow (A ≥ B unsigned).
- ZERO  out  1  RESULT == 0, held with RESULT.
- OVF  out  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN.

Behaviour:
- Reset: one clock and one synchronous active-high reset (CLK, CLR); reset polarity and synchronicity are fixed.
- CLR high at any rising edge, including mid-operation:
  - state = IDLE, counter = 0, carry FF = 0, shift registers cleared.
  - BUSY = 0, DONE = 0, RESULT = 0, CARRY = 0, ZERO = 0, OVF = 0.
  - Any in-progress operation is abandoned; no DONE is produced.
- States (enum from package): IDLE, SHIFT, FINISH.
- IDLE, START=1 at edge e0:
  - Latch a_sr = A.
  - Latch b_sr = B XOR {WIDTH{SU}} (ones-complement on subtract).
  - carry FF = SU (the +1 for two's complement), count = 0.
  - Go to SHIFT.
  - START=0: remain IDLE.
- SHIFT, each edge:
  - s = a_sr[0] ^ b_sr[0] ^ c; c ← majority(a_sr[0], b_sr[0], c).
  - r_sr ← {s, r_sr[WIDTH-1:1]}; a_sr and b_sr shift right one position; count++.
  - At the edge where count reaches WIDTH−1 (the WIDTH-th bit), go to FINISH.
  - On that same edge, load RESULT, CARRY and ZERO from the final values.
- FINISH: DONE=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - START sampled at e0; bits processed at edges e1..eWIDTH.
  - DONE high in the cycle after eWIDTH, i.e. WIDTH+1 cycles after START.
  - Earliest next START is accepted one cycle after DONE.
- BUSY = (state == SHIFT). DONE = (state == FINISH). Both are registered outputs; there is no combinational path from inputs.
- START is ignored in SHIFT and FINISH. A, B and SU may change freely after e0.
- RESULT, CARRY and ZERO change only on the edge entering FINISH. They are stable in IDLE.
- Arithmetic is modulo 2^WIDTH. Examples: 9+9 → 0010 with CARRY=1; 2−7 → 1011 with CARRY=0.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - Adds the OVF port.
  - OVF = carry into MSB XOR carry out of MSB, captured on the final SHIFT edge.
  - Held and reset like CARRY.
- Undefined:
  - OVF port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package serial_addsub_pkg:
  - state_t enum {IDLE, SHIFT, FINISH}.
  - Constants OP_ADD = 1'b0, OP_SUB = 1'b1.
- Natural sub-module serial_fa_cell: combinational single-bit full adder (a, b, cin → s, cout).
  - Instantiated once.
  - Carry FF and control stay in serial_addsub.

Test Plan:
- CLR, then A=5, B=3, SU=0, START pulse → BUSY for 4 cycles; DONE at cycle 5 after START; RESULT=1000, CARRY=0, ZERO=0; OVF=1 if enabled.
- A=9, B=9, SU=0 → RESULT=0010, CARRY=1; A=7, B=2, SU=1 → RESULT=0101, CARRY=1.
- A=2, B=7, SU=1 → RESULT=1011, CARRY=0; A=5, B=5, SU=1 → RESULT=0000, ZERO=1, CARRY=1.
- START held high continuously with changing A/B during SHIFT → only first operands used; one DONE per 6-cycle cycle (IDLE accept, 4 SHIFT, FINISH); result matches first operands.
- CLR asserted on 2nd SHIFT cycle → next cycle: all outputs 0, state IDLE, no DONE; new START completes correctly.
- Exhaustive: all A, B, SU combinations (512) against the reference model {CARRY, RESULT} = A + (B^{4{SU}}) + SU.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared types and constants for the bit-serial adder-subtracter.
//   state_t : controller states (IDLE, SHIFT, FINISH)
//   OP_ADD / OP_SUB : encodings of the SU operation select
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   START/DONE handshake and operand/result bus of the serial adder-subtracter.
//   master : controller side (drives start, su, a, b; receives results)
//   slave  : serial_addsub side
//   Optional macro SERIAL_ADDSUB_OVF_EN adds the ovf (signed overflow) signal.
interface serial_addsub_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic             su;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_ADDSUB_OVF_EN
  modport master (output start, su, a, b,
                  input  busy, done, result, carry, zero, ovf);
  modport slave  (input  start, su, a, b,
                  output busy, done, result, carry, zero, ovf);
`else
  modport master (output start, su, a, b,
                  input  busy, done, result, carry, zero);
  modport slave  (input  start, su, a, b,
                  output busy, done, result, carry, zero);
`endif

endinterface

// File: rtl/serial_addsub_fa_cell.sv
// serial_fa_cell
//   Combinational single-bit full adder.
//   a_i, b_i, cin_i : operand bits and carry in
//   s_o, cout_o     : sum bit and carry out
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial adder-subtracter: A+B or A-B, one bit per clock, LSB first,
//   through a single full-adder cell and a carry flip-flop.
//   clk_i : system clock, rising edge
//   clr_i : synchronous active-high reset
//   bus   : serial_addsub_if.slave (start, su, a, b -> busy, done, result,
//           carry, zero[, ovf])
//   Optional macro SERIAL_ADDSUB_OVF_EN adds the signed overflow flag.
//
//   state  | meaning
//   IDLE   | waiting for START; results held
//   SHIFT  | one operand bit processed per clock
//   FINISH | DONE pulse for one cycle
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk_i,
  input  logic         clr_i,
  serial_addsub_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] r_sr_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q;
`endif

  logic             s_d;
  logic             cout_d;
  logic [WIDTH-1:0] r_sr_d;
  logic             last_bit;

  serial_fa_cell u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (c_q),
    .s_o    (s_d),
    .cout_o (cout_d)
  );

  // Full result as it will look once this bit is shifted in; on the last
  // bit this is the final sum, captured directly into RESULT.
  assign r_sr_d   = {s_d, r_sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr_q  <= bus.a;
            // Subtract as A + ~B + 1: invert B here, +1 via the carry FF.
            b_sr_q  <= bus.b ^ {WIDTH{bus.su}};
            c_q     <= bus.su;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          c_q    <= cout_d;
          r_sr_q <= r_sr_d;
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            result_q <= r_sr_d;
            carry_q  <= cout_d;
            zero_q   <= (r_sr_d == '0);
`ifdef SERIAL_ADDSUB_OVF_EN
            // c_q is the carry into the MSB at this point.
            ovf_q    <= c_q ^ cout_d;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule
